// File: rtl/mem_pkg.sv
// Shared definitions for the byte-banked memory responder.
package mem_pkg;

    // Controller states
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        READY = 2'd1,
        LOAD  = 2'd2
    } memState_t;

    // Default byte capacity
    localparam int MEM_BYTES_DEF = 2048;

    // Byte lanes per 32-bit word (one bank per lane)
    localparam int LANES = 4;

endpackage

// File: rtl/mem_bank.sv
// One byte-wide storage bank: single write port, registered read port.
// The array itself is never reset; only the read register is.
module mem_bank #(
    parameter int DEPTH = 512,
    parameter int RW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [RW-1:0] wrRow,
    input  logic [7:0]    wrData,
    input  logic          re,
    input  logic [RW-1:0] rdRow,
    output logic [7:0]    rdData
);

    logic [7:0] mem [DEPTH];

    // Storage write; a same-edge read sees the old contents
    always_ff @(posedge clk) begin
        if (we) mem[wrRow] <= wrData;
    end

    // Registered read, held when no read is requested
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   rdData <= 8'h00;
        else if (re) rdData <= mem[rdRow];
    end

endmodule

// File: rtl/mem_responder.sv
// 32-bit CPU memory responder over four byte banks with unaligned,
// wrapping access, host byte preload and a power-up clear sequence.
// Optional feature: define MEM_STATS_EN to add readCount/writeCount.
// A host load strobe in READY takes priority over a CPU request that cycle.
module mem_responder
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          readReq,
    input  logic          writeReq,
    input  logic [31:0]   ramAddress,
    input  logic [31:0]   ramOut,
    output logic [31:0]   ramValue,
    input  logic          loadEn,
    input  logic [AW-1:0] loadAddr,
    input  logic [7:0]    loadByte,
    output logic          memReady,
    output logic          errAddr
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]   readCount,
    output logic [31:0]   writeCount
`endif
);

    localparam int ROWS = MEM_BYTES / LANES;
    localparam int RW   = AW - 2;

    memState_t     state;
    logic [RW-1:0] clrRow;
    logic [1:0]    rdOff;

    logic          cpuRead;
    logic          cpuWrite;
    logic          outOfRange;
    logic [1:0]    baseOff;

    logic [RW-1:0] cpuRow     [LANES];
    logic [7:0]    cpuData    [LANES];
    logic          bankWe     [LANES];
    logic [RW-1:0] bankWrRow  [LANES];
    logic [7:0]    bankWrData [LANES];
    logic [7:0]    bankRd     [LANES];

    assign cpuRead    = (state == READY) && !loadEn && readReq;
    assign cpuWrite   = (state == READY) && !loadEn && writeReq;
    assign outOfRange = (ramAddress >= 32'(MEM_BYTES));
    assign baseOff    = ramAddress[1:0];

    // Per-bank row and write byte for a CPU access starting at ramAddress
    always_comb begin
        for (int b = 0; b < LANES; b++) begin
            logic [1:0]    lane;
            logic [AW-1:0] byteAddr;
            lane       = 2'(b) - baseOff;
            byteAddr   = ramAddress[AW-1:0] + AW'(lane);
            cpuRow[b]  = byteAddr[AW-1:2];
            cpuData[b] = ramOut[8*lane +: 8];
        end
    end

    // Bank write port steering: clear, host preload, or CPU write
    always_comb begin
        for (int b = 0; b < LANES; b++) begin
            bankWe[b]     = 1'b0;
            bankWrRow[b]  = cpuRow[b];
            bankWrData[b] = cpuData[b];
            if (state == CLEAR) begin
                bankWe[b]     = 1'b1;
                bankWrRow[b]  = clrRow;
                bankWrData[b] = 8'h00;
            end else if (loadEn) begin
                bankWe[b]     = (loadAddr[1:0] == 2'(b));
                bankWrRow[b]  = loadAddr[AW-1:2];
                bankWrData[b] = loadByte;
            end else if (cpuWrite) begin
                bankWe[b]     = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : gBank
            mem_bank #(
                .DEPTH (ROWS),
                .RW    (RW)
            ) uBank (
                .clk    (clk),
                .reset  (reset),
                .we     (bankWe[g]),
                .wrRow  (bankWrRow[g]),
                .wrData (bankWrData[g]),
                .re     (cpuRead),
                .rdRow  (cpuRow[g]),
                .rdData (bankRd[g])
            );
        end
    endgenerate

    // Rotate bank read registers back into little-endian word order
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            ramValue[8*i +: 8] = bankRd[rdOff + 2'(i)];
        end
    end

    // Controller FSM with registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            clrRow     <= '0;
            memReady   <= 1'b0;
            errAddr    <= 1'b0;
            rdOff      <= 2'd0;
`ifdef MEM_STATS_EN
            readCount  <= 32'd0;
            writeCount <= 32'd0;
`endif
        end else begin
            case (state)
                CLEAR: begin
                    clrRow <= clrRow + 1'b1;
                    if (clrRow == RW'(ROWS - 1)) begin
                        state    <= READY;
                        memReady <= 1'b1;
                    end
                end
                READY: begin
                    if (loadEn) begin
                        state    <= LOAD;
                        memReady <= 1'b0;
                    end else begin
                        if (readReq) rdOff <= baseOff;
                        if ((readReq || writeReq) && outOfRange) errAddr <= 1'b1;
`ifdef MEM_STATS_EN
                        if (readReq)  readCount  <= readCount + 32'd1;
                        if (writeReq) writeCount <= writeCount + 32'd1;
`endif
                    end
                end
                LOAD: begin
                    if (!loadEn) begin
                        state    <= READY;
                        memReady <= 1'b1;
                    end
                end
                default: begin
                    state    <= CLEAR;
                    clrRow   <= '0;
                    memReady <= 1'b0;
                end
            endcase
        end
    end

endmodule
